// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared types and helpers for the run-time clock divider controller.
//   state_t         : controller state (IDLE, RUN, STOPPING)
//   DIV_W_DEFAULT   : default width of the half-period and counter registers
//   half_from_freq  : constant function giving the half-period (in input clock
//                     cycles) for a target output frequency, never below 1
// -----------------------------------------------------------------------------
package clk_div_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      STOPPING = 2'd2
   } state_t;

   localparam int unsigned DIV_W_DEFAULT = 16;

   function automatic int unsigned half_from_freq(input int unsigned freq_in,
                                                  input int unsigned f_out);
      int unsigned h;
      h = (f_out == 0) ? 1 : (freq_in / f_out / 2);
      return (h < 1) ? 1 : h;
   endfunction

endpackage

// File: rtl/clk_div_core.sv
// -----------------------------------------------------------------------------
// clk_div_core
// Counter-based 50 % duty divider. Counts input cycles while run is high and
// toggles clk_out each time the count reaches half-1. Deasserting run clears
// the counter and forces clk_out low. A new half-period is loaded on request;
// the controller only requests it in IDLE or on a falling-toggle boundary,
// where the counter is zero, so the count can never exceed the new limit.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   run        : count enable for this cycle (low = clear to idle state)
//   load       : load load_val as the new half-period at this edge
//   load_val   : new half-period in clk cycles (already clamped to >= 1)
//   clk_out    : divided clock
//   tick       : registered pulse, high in the cycle clk_out becomes 1
//   fall_evt   : combinational, this cycle's toggle drives clk_out 1->0
// -----------------------------------------------------------------------------
module clk_div_core
   import clk_div_pkg::*;
#(
   parameter int unsigned DIV_W        = DIV_W_DEFAULT,
   parameter int unsigned DEFAULT_HALF = 2500
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             load,
   input  logic [DIV_W-1:0] load_val,
   output logic             clk_out,
   output logic             tick,
   output logic             fall_evt
);

   // Only half-1 is kept: it is the sole value the counter is compared with,
   // and computing it at load time keeps the subtractor off the compare path.
   logic [DIV_W-1:0] half_m1;
   logic [DIV_W-1:0] count;
   logic             wrap;

   assign wrap     = (count == half_m1);
   assign fall_evt = clk_out & wrap;

   // NOTE: sequential state is written with non-blocking assignments so every
   // flop samples the values from before the edge, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         half_m1 <= DIV_W'(DEFAULT_HALF - 1);
      end else if (load) begin
         half_m1 <= load_val - DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (!run) begin
         count   <= '0;
         clk_out <= 1'b0;
         tick    <= 1'b0;
      end else if (wrap) begin
         count   <= '0;
         clk_out <= ~clk_out;
         tick    <= ~clk_out;
      end else begin
         count   <= count + DIV_W'(1);
         tick    <= 1'b0;
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
// Run-time controller for a divided clock: start/stop sequencing around
// clk_div_core plus a valid/ready port for reprogramming the half-period.
// A new half-period is applied in IDLE on the cycle after acceptance, or while
// running on the toggle that drives CLK_OUT 1->0, so CLK_OUT never glitches.
// Optional feature macro: CLK_DIV_CTRL_BURST_EN adds a fixed-length burst mode.
// Ports:
//   CLK_IN, RST  : system clock, asynchronous active-high reset
//   EN           : level-sensitive run request
//   CFG_VALID    : new half-period offered
//   CFG_HALF     : requested half-period in CLK_IN cycles (0 is treated as 1)
//   CFG_READY    : controller can accept a configuration
//   CLK_OUT      : divided clock, 50 % duty
//   TICK         : one-cycle pulse in the cycle CLK_OUT goes 0->1
//   BUSY         : high in RUN or STOPPING
//   BURST_START  : (burst build) start a burst from IDLE
//   BURST_LEN    : (burst build) number of full CLK_OUT periods in the burst
//   DONE         : (burst build) one-cycle pulse when a burst completes
// -----------------------------------------------------------------------------
module clk_div_ctrl
   import clk_div_pkg::*;
#(
   parameter int unsigned FREQ_IN      = 50_000_000,
   parameter int unsigned DIV_W        = DIV_W_DEFAULT,
   parameter int unsigned DEFAULT_HALF = half_from_freq(FREQ_IN, 10_000)
) (
   input  logic             CLK_IN,
   input  logic             RST,
   input  logic             EN,
   input  logic             CFG_VALID,
   input  logic [DIV_W-1:0] CFG_HALF,
   output logic             CFG_READY,
   output logic             CLK_OUT,
   output logic             TICK,
   output logic             BUSY
`ifdef CLK_DIV_CTRL_BURST_EN
   ,
   input  logic             BURST_START,
   input  logic [DIV_W-1:0] BURST_LEN,
   output logic             DONE
`endif
);

   state_t           state, next_state;
   logic             busy;
   logic             pending;
   logic [DIV_W-1:0] shadow;
   logic             accept;
   logic             apply;
   logic             run;
   logic             fall_evt;

`ifdef CLK_DIV_CTRL_BURST_EN
   logic             burst_act;
   logic [DIV_W-1:0] burst_rem;
   logic             done;
   logic             burst_last;

   assign burst_last = burst_act & fall_evt & (burst_rem == DIV_W'(1));
   assign DONE       = done;
`endif

   // -------------------------------------------------------------------------
   // Configuration handshake. accept and apply are mutually exclusive because
   // one needs pending low and the other needs it high.
   // -------------------------------------------------------------------------
   assign CFG_READY = ~pending;
   assign accept    = CFG_VALID & ~pending;
   assign apply     = pending & ((state == IDLE) | fall_evt);

   // NOTE: the shadow register is reset like any other flop; it is a single
   // word, not a memory, and a known value keeps simulation free of X.
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         pending <= 1'b0;
         shadow  <= '0;
      end else if (accept) begin
         pending <= 1'b1;
         shadow  <= (CFG_HALF == '0) ? DIV_W'(1) : CFG_HALF;
      end else if (apply) begin
         pending <= 1'b0;
      end
   end

   // -------------------------------------------------------------------------
   // Start/stop FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (EN) begin
               next_state = RUN;
            end
`ifdef CLK_DIV_CTRL_BURST_EN
            else if (BURST_START && (BURST_LEN != '0)) begin
               next_state = RUN;
            end
`endif
         end
         RUN: begin
            if (!EN) begin
`ifdef CLK_DIV_CTRL_BURST_EN
               if (burst_act) begin
                  if (burst_last) next_state = IDLE;
               end else
`endif
               // Low phase (or this cycle's toggle is the fall): stop now,
               // truncating the low phase with no extra edge.
               if (!CLK_OUT || fall_evt) next_state = IDLE;
               else                      next_state = STOPPING;
            end
         end
         STOPPING: begin
            if (EN)            next_state = RUN;
            else if (fall_evt) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // The core only counts when it is running both before and after this edge:
   // the entry edge leaves count at 0 (so the first rise lands `half` cycles
   // after entry) and the exit edge clears count and CLK_OUT.
   assign run  = (state != IDLE) && (next_state != IDLE);
   assign BUSY = busy;

`ifdef CLK_DIV_CTRL_BURST_EN
   // -------------------------------------------------------------------------
   // Burst bookkeeping: counts 1->0 toggles; EN high turns a burst into
   // free-running mode.
   // -------------------------------------------------------------------------
   always_ff @(posedge CLK_IN or posedge RST) begin
      if (RST) begin
         burst_act <= 1'b0;
         burst_rem <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (BURST_START && !EN) begin
               burst_act <= (BURST_LEN != '0);
               burst_rem <= BURST_LEN;
               done      <= (BURST_LEN == '0);
            end
         end else if (EN) begin
            burst_act <= 1'b0;
         end else if (burst_act && fall_evt) begin
            burst_rem <= burst_rem - DIV_W'(1);
            if (burst_last) begin
               burst_act <= 1'b0;
               done      <= 1'b1;
            end
         end
      end
   end
`endif

   clk_div_core #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
   ) u_core (
      .clk      (CLK_IN),
      .rst      (RST),
      .run      (run),
      .load     (apply),
      .load_val (shadow),
      .clk_out  (CLK_OUT),
      .tick     (TICK),
      .fall_evt (fall_evt)
   );

endmodule

// File: tb/tb_clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_div_ctrl
// Self-checking bench for clk_div_ctrl built with DEFAULT_HALF=4. Each test
// pushes the cycles at which TICK, CLK_OUT 1->0 (and DONE in the burst build)
// must occur; a monitor records what the DUT does and the test pops and
// compares both queues. Cycle n is the value of cyc after the n-th rising edge.
// -----------------------------------------------------------------------------
module tb_clk_div_ctrl;

   localparam int DW = 16;
   localparam int DH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          cfg_valid;
   logic [DW-1:0] cfg_half;
   logic          cfg_ready;
   logic          clk_out;
   logic          tick;
   logic          busy;
`ifdef CLK_DIV_CTRL_BURST_EN
   logic          burst_start;
   logic [DW-1:0] burst_len;
   logic          done;
`endif

   clk_div_ctrl #(
      .FREQ_IN      (50_000_000),
      .DIV_W        (DW),
      .DEFAULT_HALF (DH)
   ) dut (
      .CLK_IN    (clk),
      .RST       (rst),
      .EN        (en),
      .CFG_VALID (cfg_valid),
      .CFG_HALF  (cfg_half),
      .CFG_READY (cfg_ready),
      .CLK_OUT   (clk_out),
      .TICK      (tick),
      .BUSY      (busy)
`ifdef CLK_DIV_CTRL_BURST_EN
      ,
      .BURST_START (burst_start),
      .BURST_LEN   (burst_len),
      .DONE        (done)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef enum logic [1:0] {EV_TICK, EV_FALL, EV_DONE} ev_kind_t;
   typedef struct packed {
      ev_kind_t    kind;
      logic [31:0] at;
   } ev_t;

   ev_t  exp_q[$];
   ev_t  obs_q[$];
   bit   mon_on = 1'b0;
   logic prev_clk_out = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic ev_t mk_ev(ev_kind_t k, int c);
      ev_t e;
      e.kind = k;
      e.at   = c;
      return e;
   endfunction

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mon_on) begin
         if (tick)                    obs_q.push_back(mk_ev(EV_TICK, cyc));
         if (prev_clk_out && !clk_out) obs_q.push_back(mk_ev(EV_FALL, cyc));
`ifdef CLK_DIV_CTRL_BURST_EN
         if (done)                    obs_q.push_back(mk_ev(EV_DONE, cyc));
`endif
      end
      prev_clk_out = clk_out;
   end

   // Stimulus and checks act 1 ns after the falling edge, after the monitor.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic step_to(int c);
      while (cyc < c) step();
   endtask

   task automatic expect_ev(ev_kind_t k, int c);
      exp_q.push_back(mk_ev(k, c));
   endtask

   task automatic begin_obs();
      exp_q.delete();
      obs_q.delete();
      mon_on = 1'b1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      en        = 1'b0;
      cfg_valid = 1'b0;
      cfg_half  = '0;
`ifdef CLK_DIV_CTRL_BURST_EN
      burst_start = 1'b0;
      burst_len   = '0;
`endif
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // Program a half-period while IDLE: accept, apply, READY back high.
   task automatic load_half(int h);
      cfg_half  = DW'(h);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      step();
      step();
   endtask

   // -------------------------------------------------------------------------
   task automatic test_reset();
      do_reset();
      step();
      #2 rst = 1'b1;
      #1;
      n_cmp += 4;
      if (clk_out !== 1'b0)   begin n_bad++; $display("FAIL reset_clk_out: got %b want 0", clk_out); end
      if (tick !== 1'b0)      begin n_bad++; $display("FAIL reset_tick: got %b want 0", tick); end
      if (busy !== 1'b0)      begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
      step();
      rst = 1'b0;
      step();
   endtask

   // half=4: first TICK 4 cycles after RUN entry, then every 8 cycles.
   task automatic test_run();
      int n;
      ev_t e, a;
      do_reset();
      begin_obs();
      n  = cyc;
      en = 1'b1;
      expect_ev(EV_TICK, n + 5);
      expect_ev(EV_FALL, n + 9);
      expect_ev(EV_TICK, n + 13);
      expect_ev(EV_FALL, n + 17);
      expect_ev(EV_TICK, n + 21);
      step();
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL run_busy: got %b want 1", busy); end
      step_to(n + 22);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL run_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL run_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
      en = 1'b0;
   endtask

   // Reprogram to 2 during the high phase; applied at the next fall.
   task automatic test_cfg_run();
      int n;
      ev_t e, a;
      do_reset();
      begin_obs();
      n  = cyc;
      en = 1'b1;
      expect_ev(EV_TICK, n + 5);
      expect_ev(EV_FALL, n + 9);
      expect_ev(EV_TICK, n + 11);
      expect_ev(EV_FALL, n + 13);
      expect_ev(EV_TICK, n + 15);
      expect_ev(EV_FALL, n + 17);
      step_to(n + 6);
      cfg_half  = DW'(2);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_cmp++;
      if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_ready_after_accept: got %b want 0", cfg_ready); end
      step();
      n_cmp++;
      if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL cfg_ready_pending: got %b want 0", cfg_ready); end
      step();
      n_cmp += 2;
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL cfg_ready_after_apply: got %b want 1", cfg_ready); end
      if (clk_out !== 1'b0)   begin n_bad++; $display("FAIL cfg_boundary_clk_out: got %b want 0", clk_out); end
      step_to(n + 18);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL cfg_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL cfg_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
      en = 1'b0;
   endtask

   // CFG_HALF=0 is clamped to 1: CLK_OUT toggles every cycle.
   task automatic test_clamp();
      int n;
      ev_t e, a;
      do_reset();
      n         = cyc;
      cfg_half  = '0;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_cmp++;
      if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL clamp_ready_low: got %b want 0", cfg_ready); end
      step();
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL clamp_ready_high: got %b want 1", cfg_ready); end
      begin_obs();
      en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         expect_ev(EV_TICK, n + 4 + 2 * k);
         if (k < 3) expect_ev(EV_FALL, n + 5 + 2 * k);
      end
      step_to(n + 10);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL clamp_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL clamp_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
      en = 1'b0;
   endtask

   // half=5: EN falls in the high phase (finish the phase) and in the low
   // phase (stop at once, count cleared so the restart takes a full half).
   task automatic test_stop();
      int n, m;
      ev_t e, a;
      do_reset();
      load_half(5);
      begin_obs();
      n  = cyc;
      en = 1'b1;
      expect_ev(EV_TICK, n + 6);
      expect_ev(EV_FALL, n + 11);
      step_to(n + 7);
      en = 1'b0;
      step_to(n + 10);
      n_cmp += 2;
      if (clk_out !== 1'b1) begin n_bad++; $display("FAIL stop_hold_high: got %b want 1", clk_out); end
      if (busy !== 1'b1)    begin n_bad++; $display("FAIL stop_busy_stopping: got %b want 1", busy); end
      step();
      n_cmp += 2;
      if (clk_out !== 1'b0) begin n_bad++; $display("FAIL stop_fall: got %b want 0", clk_out); end
      if (busy !== 1'b0)    begin n_bad++; $display("FAIL stop_busy_idle: got %b want 0", busy); end
      step_to(n + 25);
      m  = cyc;
      en = 1'b1;
      expect_ev(EV_TICK, m + 6);
      expect_ev(EV_FALL, m + 11);
      expect_ev(EV_TICK, m + 20);
      step_to(m + 13);
      en = 1'b0;
      step();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL stop_low_phase_busy: got %b want 0", busy); end
      en = 1'b1;
      step_to(m + 22);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL stop_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL stop_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
      en = 1'b0;
   endtask

   // Asynchronous reset in the high phase with a configuration pending.
   task automatic test_reset_mid();
      int n, k;
      ev_t e, a;
      do_reset();
      n  = cyc;
      en = 1'b1;
      step_to(n + 6);
      cfg_half  = DW'(7);
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_cmp += 2;
      if (cfg_ready !== 1'b0) begin n_bad++; $display("FAIL rmid_pending: got %b want 0", cfg_ready); end
      if (clk_out !== 1'b1)   begin n_bad++; $display("FAIL rmid_high_before: got %b want 1", clk_out); end
      #2 rst = 1'b1;
      #1;
      n_cmp += 4;
      if (clk_out !== 1'b0)   begin n_bad++; $display("FAIL rmid_clk_out: got %b want 0", clk_out); end
      if (tick !== 1'b0)      begin n_bad++; $display("FAIL rmid_tick: got %b want 0", tick); end
      if (busy !== 1'b0)      begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_cfg_ready: got %b want 1", cfg_ready); end
      en = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      step();
      n_cmp++;
      if (cfg_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready_after: got %b want 1", cfg_ready); end
      begin_obs();
      k  = cyc;
      en = 1'b1;
      expect_ev(EV_TICK, k + DH + 1);
      expect_ev(EV_FALL, k + 2 * DH + 1);
      expect_ev(EV_TICK, k + 3 * DH + 1);
      step_to(k + 13);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL rmid_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL rmid_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
      en = 1'b0;
   endtask

`ifdef CLK_DIV_CTRL_BURST_EN
   // half=2, three-period burst, then a zero-length burst.
   task automatic test_burst();
      int n, m;
      ev_t e, a;
      do_reset();
      load_half(2);
      begin_obs();
      n           = cyc;
      burst_len   = DW'(3);
      burst_start = 1'b1;
      for (int k = 0; k < 3; k++) begin
         expect_ev(EV_TICK, n + 3 + 4 * k);
         expect_ev(EV_FALL, n + 5 + 4 * k);
      end
      expect_ev(EV_DONE, n + 13);
      step();
      burst_start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1) begin n_bad++; $display("FAIL burst_busy: got %b want 1", busy); end
      step_to(n + 13);
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_idle: got %b want 0", busy); end
      step_to(n + 18);
      m           = cyc;
      burst_len   = '0;
      burst_start = 1'b1;
      expect_ev(EV_DONE, m + 1);
      step();
      burst_start = 1'b0;
      step_to(m + 8);
      mon_on = 1'b0;
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_bad++; $display("FAIL burst_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); a = obs_q.pop_front(); n_cmp++;
         if (a !== e) begin n_bad++; $display("FAIL burst_event: got %s@%0d want %s@%0d", a.kind.name(), a.at, e.kind.name(), e.at); end
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_run();
      test_cfg_run();
      test_clamp();
      test_stop();
      test_reset_mid();
`ifdef CLK_DIV_CTRL_BURST_EN
      test_burst();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
